boot_loader: RTL

Hardware image loader that replaces the simulation-only `$fread` memory preload in the top level. It accepts a byte stream for the code and data segments, packs the bytes into `WORD_BYTES`-wide memory-bus write requests, and issues those writes to DRAM with a valid/ready handshake. Once both segments are written, it releases `NUM_CORES` cores from halt one per cycle. It sits between an external image source (testbench or debug port) and the memory bus, ahead of the per-core fetch stages.

---
 rtl/boot_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Image loader: packs a code/data byte stream into word-wide memory writes,
// then releases the cores from halt one per cycle once both segments are in memory.
module boot_loader #(
    parameter int NUM_CORES = 1,
    parameter int ADDR_WIDTH = 21,
    parameter int WORD_BYTES = 8,
    parameter logic [ADDR_WIDTH-1:0] CODE_BASE = ADDR_WIDTH'(21'h000000),
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE = ADDR_WIDTH'(21'h010000)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_seg,
    input  logic                    in_last,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic [WORD_BYTES-1:0]   mem_byte_en,
    output logic [NUM_CORES-1:0]    core_run,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             byte_count
);
    localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WRITE, S_RELEASE, S_DONE, S_ERROR
    } state_t;

    // Handshakes: a byte moves on a cycle with in_valid && in_ready, a write
    // moves on a cycle with mem_req_valid && mem_req_ready; the payload of a
    // pending request stays frozen until it moves.
    state_t                  state, state_n;
    logic [LW-1:0]           lane_idx, lane_n;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_n;
    logic                    seg, seg_n;
    logic                    seg_open, seg_open_n;
    logic                    seg_end, seg_end_n;
    logic [1:0]              loaded, loaded_n;
    logic [8*WORD_BYTES-1:0] wdata, wdata_n;
    logic [WORD_BYTES-1:0]   byte_en, byte_en_n;
    logic [31:0]             count, count_n;
    logic [NUM_CORES-1:0]    run, run_n;
    logic [ADDR_WIDTH:0]     ptr_sum;
    logic                    cur_seg;
    logic [ADDR_WIDTH-1:0]   cur_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            lane_idx <= '0;
            ptr      <= '0;
            seg      <= 1'b0;
            seg_open <= 1'b1;
            seg_end  <= 1'b0;
            loaded   <= '0;
            wdata    <= '0;
            byte_en  <= '0;
            count    <= '0;
            run      <= '0;
        end else begin
            state    <= state_n;
            lane_idx <= lane_n;
            ptr      <= ptr_n;
            seg      <= seg_n;
            seg_open <= seg_open_n;
            seg_end  <= seg_end_n;
            loaded   <= loaded_n;
            wdata    <= wdata_n;
            byte_en  <= byte_en_n;
            count    <= count_n;
            run      <= run_n;
        end
    end

    always_comb begin
        state_n    = state;
        lane_n     = lane_idx;
        ptr_n      = ptr;
        seg_n      = seg;
        seg_open_n = seg_open;
        seg_end_n  = seg_end;
        loaded_n   = loaded;
        wdata_n    = wdata;
        byte_en_n  = byte_en;
        count_n    = count;
        run_n      = run;
        // The extra top bit of the sum is the carry that flags address overflow.
        ptr_sum    = {1'b0, ptr} + (ADDR_WIDTH+1)'(WORD_BYTES);
        cur_seg    = seg_open ? in_seg : seg;
        cur_ptr    = seg_open ? (in_seg ? DATA_BASE : CODE_BASE) : ptr;

        case (state)
            S_IDLE: begin
                if (start) state_n = S_FILL;
            end
            S_FILL: begin
                if (in_valid) begin
                    if (loaded[cur_seg]) begin
                        state_n = S_ERROR;
                    end else begin
                        seg_n                      = cur_seg;
                        ptr_n                      = cur_ptr;
                        seg_open_n                 = 1'b0;
                        seg_end_n                  = in_last;
                        wdata_n[{lane_idx, 3'b000} +: 8] = in_data;
                        byte_en_n[lane_idx]        = 1'b1;
                        count_n                    = count + 32'd1;
                        if (lane_idx == LW'(WORD_BYTES-1) || in_last) state_n = S_WRITE;
                        else lane_n = lane_idx + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (mem_req_ready) begin
                    lane_n    = '0;
                    wdata_n   = '0;
                    byte_en_n = '0;
                    if (ptr_sum[ADDR_WIDTH]) begin
                        state_n = S_ERROR;
                    end else begin
                        ptr_n   = ptr_sum[ADDR_WIDTH-1:0];
                        state_n = S_FILL;
                        if (seg_end) begin
                            loaded_n[seg] = 1'b1;
                            seg_open_n    = 1'b1;
                            seg_end_n     = 1'b0;
                            if (loaded_n == 2'b11) state_n = S_RELEASE;
                        end
                    end
                end
            end
            S_RELEASE: begin
                // Checking the registered top bit delays done by one cycle past all-ones.
                if (run[NUM_CORES-1]) state_n = S_DONE;
                else run_n = (run << 1) | NUM_CORES'(1);
            end
            S_ERROR: begin
                run_n = '0;
            end
            default: ;
        endcase
    end

    assign in_ready      = (state == S_FILL);
    assign mem_req_valid = (state == S_WRITE);
    assign done          = (state == S_DONE);
    assign error         = (state == S_ERROR);
    assign mem_addr      = ptr;
    assign mem_wdata     = wdata;
    assign mem_byte_en   = byte_en;
    assign core_run      = run;
    assign byte_count    = count;
endmodule
